// File: rtl/iterative_divider_pkg.sv
// Shared constants for the RV32M iterative divider: operation and FSM state
// encodings, datapath width, and a magnitude helper.
package iterative_divider_pkg;

    localparam int XLEN        = 32;
    localparam int COUNT_WIDTH = 6;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [XLEN-1:0] ZERO         = '0;
    localparam logic [XLEN-1:0] ALL_ONES     = '1;
    localparam logic [XLEN-1:0] MOST_NEG_INT = {1'b1, {(XLEN-1){1'b0}}};

    // Two's-complement magnitude; 0x80000000 maps to the unsigned value 2^31.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish at acceptance.
module iterative_divider
    import iterative_divider_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            request_valid,
    output logic            request_ready,
    input  logic [1:0]      request_op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            response_valid,
    input  logic            response_ready,
    output logic [XLEN-1:0] result
);

    logic [1:0]             state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic                   sign_a_q, sign_a_d;
    logic                   sign_b_q, sign_b_d;
    logic [XLEN-1:0]        quo_q, quo_d;
    logic [XLEN-1:0]        rem_q, rem_d;
    logic [XLEN-1:0]        div_q, div_d;
    logic [XLEN-1:0]        result_q, result_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic            accept;
    logic            req_signed;
    logic            op_signed;
    logic [XLEN:0]   shifted_rem;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] quo_fixed;
    logic [XLEN-1:0] rem_fixed;

    assign request_ready  = (state_q == ST_IDLE);
    assign response_valid = (state_q == ST_DONE);
    assign result         = result_q;

    assign accept     = request_valid && request_ready;
    assign req_signed = !request_op[0];
    assign op_signed  = !op_q[0];

    // The top dividend bit enters the remainder; the trial sign decides the quotient bit.
    assign shifted_rem = {rem_q, quo_q[XLEN-1]};
    assign trial       = shifted_rem - {1'b0, div_q};

    // A zero divisor leaves the all-ones quotient untouched even when signs differ.
    assign quo_fixed = (op_signed && (sign_a_q ^ sign_b_q) && (div_q != ZERO)) ? -quo_q : quo_q;
    assign rem_fixed = (op_signed && sign_a_q) ? -rem_q : rem_q;

`ifdef DIV_EARLY_OUT_EN
    logic            early_div0;
    logic            early_ovf;
    logic [XLEN-1:0] early_result;

    assign early_div0   = (operand_b == ZERO);
    assign early_ovf    = req_signed && (operand_a == MOST_NEG_INT) && (operand_b == ALL_ONES);
    assign early_result = request_op[1] ? (early_div0 ? operand_a : ZERO)
                                        : (early_div0 ? ALL_ONES  : operand_a);
`endif

    always_comb begin
        // NOTE: every next-state signal defaults to its register so no path infers a latch.
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        div_d    = div_q;
        result_d = result_q;
        count_d  = count_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d     = request_op;
                    sign_a_d = operand_a[XLEN-1];
                    sign_b_d = operand_b[XLEN-1];
                    quo_d    = magnitude(operand_a, req_signed);
                    div_d    = magnitude(operand_b, req_signed);
                    rem_d    = ZERO;
                    count_d  = COUNT_WIDTH'(XLEN);
                    state_d  = ST_BUSY;
`ifdef DIV_EARLY_OUT_EN
                    if (early_div0 || early_ovf) begin
                        result_d = early_result;
                        state_d  = ST_DONE;
                    end
`endif
                end
            end
            ST_BUSY: begin
                if (!trial[XLEN]) begin
                    rem_d = trial[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = shifted_rem[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                count_d = count_q - COUNT_WIDTH'(1);
                if (count_q == COUNT_WIDTH'(1)) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                result_d = op_q[1] ? rem_fixed : quo_fixed;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (response_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: datapath registers are reset too, so an aborted operation leaves no stale result.
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= DIV_OP_DIV;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            quo_q    <= ZERO;
            rem_q    <= ZERO;
            div_q    <= ZERO;
            result_q <= ZERO;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            result_q <= result_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed RV32M cases, scoreboard of
// expected results, latency, backpressure and mid-operation reset.
module tb_iterative_divider;

    logic        clock = 1'b0;
    logic        reset;
    logic        request_valid;
    logic        request_ready;
    logic [1:0]  request_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        response_valid;
    logic        response_ready;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
    localparam int FULL_LAT = 33;
`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 0;
`else
    localparam int EARLY_LAT = 33;
`endif

    iterative_divider dut (
        .clock          (clock),
        .reset          (reset),
        .request_valid  (request_valid),
        .request_ready  (request_ready),
        .request_op     (request_op),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .response_valid (response_valid),
        .response_ready (response_ready),
        .result         (result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference RV32M semantics, independent of the shift/subtract algorithm.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
        case (op)
            OP_DIV:  return $signed(a) / $signed(b);
            OP_DIVU: return a / b;
            OP_REM:  return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    // Drive one request, scramble the inputs after acceptance, measure latency.
    task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, output int lat);
        exp_q.push_back(exp);
        check({tag, " request_ready idle"}, {31'b0, request_ready}, 32'd1);
        request_valid = 1'b1;
        request_op    = op;
        operand_a     = a;
        operand_b     = b;
        @(posedge clock); #1;
        request_valid = 1'b0;
        request_op    = 2'($urandom);
        operand_a     = $urandom;
        operand_b     = $urandom;
        lat = 0;
        while (!response_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic pop_and_compare(input string tag);
        logic [31:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check({tag, " result"}, result, e);
    endtask

    task automatic consume(input string tag);
        response_ready = 1'b1;
        @(posedge clock); #1;
        response_ready = 1'b0;
        check({tag, " response_valid cleared"}, {31'b0, response_valid}, 32'd0);
        check({tag, " request_ready restored"}, {31'b0, request_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(tag, op, a, b, exp, lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        pop_and_compare(tag);
        consume(tag);
    endtask

    initial begin
        int          lat;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        reset          = 1'b1;
        request_valid  = 1'b0;
        request_op     = 2'b00;
        operand_a      = 32'h0;
        operand_b      = 32'h0;
        response_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset request_ready", {31'b0, request_ready}, 32'd1);
        check("reset response_valid", {31'b0, response_valid}, 32'd0);
        check("reset result", result, 32'h0);
        reset = 1'b0;
        @(posedge clock); #1;

        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT);
        run_op("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, FULL_LAT);
        run_op("div -7/2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, FULL_LAT);
        run_op("rem -7/2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, FULL_LAT);
        run_op("div 7/-2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, FULL_LAT);
        run_op("rem 7/-2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, FULL_LAT);
        run_op("div 5/0",    OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, EARLY_LAT);
        run_op("remu 5/0",   OP_REMU, 32'd5, 32'd0, 32'd5, EARLY_LAT);
        run_op("div -5/0",   OP_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, EARLY_LAT);
        run_op("rem -5/0",   OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, EARLY_LAT);
        run_op("div ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EARLY_LAT);
        run_op("rem ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, EARLY_LAT);
        run_op("divu big",   OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, FULL_LAT);
        run_op("div minint/2", OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, FULL_LAT);

        for (int i = 0; i < 6; i++) begin
            rop = 2'(i);
            ra  = $urandom;
            rb  = $urandom >> (i * 4);
            if (rb == 32'h0) rb = 32'd3;
            run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb), FULL_LAT);
        end

        // Backpressure: early response_ready is ignored, then hold the result for 10 cycles.
        exp_q.push_back(32'd100);
        request_valid = 1'b1;
        request_op    = OP_DIVU;
        operand_a     = 32'd1000;
        operand_b     = 32'd10;
        @(posedge clock); #1;
        request_valid  = 1'b0;
        response_ready = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        response_ready = 1'b0;
        check("bp busy request_ready", {31'b0, request_ready}, 32'd0);
        check("bp busy response_valid", {31'b0, response_valid}, 32'd0);
        lat = 5;
        while (!response_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        check("bp latency", 32'(lat), 32'(FULL_LAT));
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            check($sformatf("bp hold%0d valid", i), {31'b0, response_valid}, 32'd1);
            check($sformatf("bp hold%0d ready", i), {31'b0, request_ready}, 32'd0);
            check($sformatf("bp hold%0d result", i), result, 32'd100);
        end
        pop_and_compare("bp");
        consume("bp");

        // Reset during BUSY discards the pending operation.
        exp_q.push_back(32'd7);
        request_valid = 1'b1;
        request_op    = OP_DIVU;
        operand_a     = 32'd49;
        operand_b     = 32'd7;
        @(posedge clock); #1;
        request_valid = 1'b0;
        repeat (15) @(posedge clock);
        #1;
        check("rst busy request_ready", {31'b0, request_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
        check("rst abort request_ready", {31'b0, request_ready}, 32'd1);
        check("rst abort response_valid", {31'b0, response_valid}, 32'd0);
        check("rst abort result", result, 32'h0);
        repeat (40) @(posedge clock);
        #1;
        check("rst no stale response", {31'b0, response_valid}, 32'd0);
        run_op("divu 9/3 after reset", OP_DIVU, 32'd9, 32'd3, 32'd3, FULL_LAT);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
